// File: rtl/delay_timer_pkg.sv
// Shared types and fixed-point helpers for the multi-channel delay timer.
package delay_timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FIRE  = 2'd2
   } state_t;

   // Full width of the delay*PREC_DIV product before the fractional shift.
   function automatic int cw(input int dw, input int fb, input int pd);
      return dw + fb + $clog2(pd + 1);
   endfunction

   // Width of a tick count once the fractional bits are shifted out.
   function automatic int tick_w(input int dw, input int pd);
      return dw + $clog2(pd + 1);
   endfunction

   // Round-half-up conversion from fixed-point time units to precision ticks.
   function automatic logic [63:0] to_ticks(input logic [63:0] d, input int fb, input int pd);
      logic [63:0] half;
      half = (fb > 0) ? (64'd1 << (fb - 1)) : 64'd0;
      return (d * 64'(pd) + half) >> fb;
   endfunction

endpackage

// File: rtl/delay_timer_chan.sv
// One timer channel: trigger edge detect, tick countdown FSM and fire-time stamp.
// With DELAY_TIMER_RETRIG_EN defined, an edge while ARMED restarts the interval.
module delay_timer_chan
   import delay_timer_pkg::*;
#(
   parameter int DW        = 16,
   parameter int FRAC_BITS = 4,
   parameter int PREC_DIV  = 10,
   parameter int TW        = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick_en,
   input  logic                    trig,
   input  logic [DW+FRAC_BITS-1:0] delay,
   input  logic [TW-1:0]           now,
   output state_t                  state,
   output logic [TW-1:0]           stamp
);

   localparam int TKW = tick_w(DW, PREC_DIV);

   logic           trig_q;
   logic           rise;
   logic [TKW-1:0] ticks;
   logic [TKW-1:0] cnt;
   logic [TKW-1:0] cnt_n;
   state_t         state_n;
   state_t         load_state;

   assign rise       = trig & ~trig_q;
   assign ticks      = TKW'(to_ticks(64'(delay), FRAC_BITS, PREC_DIV));
   assign load_state = (ticks == '0) ? FIRE : ARMED;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (rise) begin
               cnt_n   = ticks;
               state_n = load_state;
            end
         end
         ARMED: begin
`ifdef DELAY_TIMER_RETRIG_EN
            if (rise) begin
               cnt_n   = ticks;
               state_n = load_state;
            end else if (tick_en) begin
               cnt_n = cnt - 1'b1;
               if (cnt == TKW'(1)) state_n = FIRE;
            end
`else
            if (tick_en) begin
               cnt_n = cnt - 1'b1;
               if (cnt == TKW'(1)) state_n = FIRE;
            end
`endif
         end
         FIRE: begin
            // A fresh edge while firing starts the next interval immediately.
            if (rise) begin
               cnt_n   = ticks;
               state_n = load_state;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         trig_q <= 1'b0;
         stamp  <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         trig_q <= trig;
         if (state == FIRE) stamp <= now;
      end
   end

endmodule

// File: rtl/delay_timer_mc.sv
// N-channel fractional-delay timer; owns the shared free-running tick counter.
// Build option DELAY_TIMER_RETRIG_EN selects restart-on-edge while a channel is armed.
module delay_timer_mc
   import delay_timer_pkg::*;
#(
   parameter int NCHAN     = 2,
   parameter int DW        = 16,
   parameter int FRAC_BITS = 4,
   parameter int PREC_DIV  = 10,
   parameter int TW        = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tick_en,
   input  logic [NCHAN-1:0]              trig,
   input  logic [NCHAN*(DW+FRAC_BITS)-1:0] delay,
   output logic [NCHAN-1:0]              busy,
   output logic [NCHAN-1:0]              done,
   output logic [NCHAN*TW-1:0]           stamp,
   output logic [TW-1:0]                 now
);

   logic [TW-1:0] now_q;
   state_t        chan_state [NCHAN];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          now_q <= '0;
      else if (tick_en) now_q <= now_q + 1'b1;
   end

   assign now = now_q;

   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      delay_timer_chan #(
         .DW        (DW),
         .FRAC_BITS (FRAC_BITS),
         .PREC_DIV  (PREC_DIV),
         .TW        (TW)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .tick_en (tick_en),
         .trig    (trig[i]),
         .delay   (delay[i*(DW+FRAC_BITS) +: (DW+FRAC_BITS)]),
         .now     (now_q),
         .state   (chan_state[i]),
         .stamp   (stamp[i*TW +: TW])
      );

      assign busy[i] = (chan_state[i] != IDLE);
      assign done[i] = (chan_state[i] == FIRE);
   end

endmodule
